// File: rtl/rd0_fifo_64to16.sv
// Dual-clock 64-to-16 width-converting FIFO: word-addressed write port, lane-addressed read port,
// Gray-coded pointers with 2-flop synchronizers and registered, pessimistic status flags.
module rd0_fifo_64to16 #(
    parameter int WR_DEPTH_WIDTH   = 9,
    parameter int WR_DATA_WIDTH    = 64,
    parameter int RD_DEPTH_WIDTH   = 11,
    parameter int RD_DATA_WIDTH    = 16,
    parameter int ALMOST_FULL_NUM  = 256,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                      wr_clk,
    input  logic                      rd_clk,
    input  logic                      wr_rst,
    input  logic                      rd_rst,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic                      almost_empty
);

    localparam int LANE_BITS = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
    localparam int LANES     = 1 << LANE_BITS;
    localparam int WORDS     = 1 << WR_DEPTH_WIDTH;
    localparam logic [WR_DEPTH_WIDTH:0] FULL_LEVEL = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    localparam logic [WR_DEPTH_WIDTH:0] AF_LEVEL   = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
    localparam logic [RD_DEPTH_WIDTH:0] AE_LEVEL   = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

    logic [WR_DATA_WIDTH-1:0] mem [0:WORDS-1];

    logic [WR_DEPTH_WIDTH:0] wr_ptr_reg, wr_ptr_next, wr_gray_reg;
    logic [WR_DEPTH_WIDTH:0] wr_gray_sync1_reg, wr_gray_sync2_reg, wr_ptr_sync_bin;
    logic [WR_DEPTH_WIDTH:0] wr_level_next, wr_level_reg;
    logic                    wr_full_reg, almost_full_reg, wr_accept;

    logic [RD_DEPTH_WIDTH:0] rd_ptr_reg, rd_ptr_next, rd_gray_reg;
    logic [RD_DEPTH_WIDTH:0] rd_gray_sync1_reg, rd_gray_sync2_reg, rd_ptr_sync_bin;
    logic [RD_DEPTH_WIDTH:0] rd_level_next;
    logic                    rd_empty_reg, almost_empty_reg, rd_accept;
    logic [RD_DATA_WIDTH-1:0] rd_data_reg;
    logic [WR_DATA_WIDTH-1:0] rd_word;
    logic [RD_DATA_WIDTH-1:0] rd_lanes [LANES];
    logic                     rd_sync_lane_unused;

    // Gray-to-binary on the synchronized pointers: bit i is the XOR of all Gray bits at or above i.
    genvar gi;
    generate
        for (gi = 0; gi <= WR_DEPTH_WIDTH; gi++) begin : g_wr_g2b
            assign wr_ptr_sync_bin[gi] = ^wr_gray_sync2_reg[WR_DEPTH_WIDTH:gi];
        end
        for (gi = 0; gi <= RD_DEPTH_WIDTH; gi++) begin : g_rd_g2b
            assign rd_ptr_sync_bin[gi] = ^rd_gray_sync2_reg[RD_DEPTH_WIDTH:gi];
        end
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign rd_lanes[gi] = rd_word[gi*RD_DATA_WIDTH +: RD_DATA_WIDTH];
        end
    endgenerate

    // The write side only frees whole words, so the lane bits of the read pointer are not needed there.
    assign rd_sync_lane_unused = ^rd_ptr_sync_bin[LANE_BITS-1:0];

    // ---------------- write domain ----------------
    assign wr_accept     = wr_en & ~wr_full_reg;
    assign wr_ptr_next   = wr_ptr_reg + {{WR_DEPTH_WIDTH{1'b0}}, wr_accept};
    assign wr_level_next = wr_ptr_next - rd_ptr_sync_bin[RD_DEPTH_WIDTH:LANE_BITS];

    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[WR_DEPTH_WIDTH-1:0]] <= wr_data;
        end
    end

    // Flags are computed from the next pointer so a write is reflected on the very next cycle.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wr_ptr_reg        <= '0;
            wr_gray_reg       <= '0;
            rd_gray_sync1_reg <= '0;
            rd_gray_sync2_reg <= '0;
            wr_level_reg      <= '0;
            wr_full_reg       <= 1'b0;
            almost_full_reg   <= 1'b0;
        end else begin
            wr_ptr_reg        <= wr_ptr_next;
            wr_gray_reg       <= wr_ptr_next ^ (wr_ptr_next >> 1);
            rd_gray_sync1_reg <= rd_gray_reg;
            rd_gray_sync2_reg <= rd_gray_sync1_reg;
            wr_level_reg      <= wr_level_next;
            wr_full_reg       <= (wr_level_next == FULL_LEVEL);
            almost_full_reg   <= (wr_level_next >= AF_LEVEL);
        end
    end

    // ---------------- read domain ----------------
    assign rd_accept     = rd_en & ~rd_empty_reg;
    assign rd_ptr_next   = rd_ptr_reg + {{RD_DEPTH_WIDTH{1'b0}}, rd_accept};
    assign rd_level_next = {wr_ptr_sync_bin, {LANE_BITS{1'b0}}} - rd_ptr_next;
    assign rd_word       = mem[rd_ptr_reg[RD_DEPTH_WIDTH-1:LANE_BITS]];

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr_reg        <= '0;
            rd_gray_reg       <= '0;
            wr_gray_sync1_reg <= '0;
            wr_gray_sync2_reg <= '0;
            rd_empty_reg      <= 1'b1;
            almost_empty_reg  <= 1'b1;
            rd_data_reg       <= '0;
        end else begin
            rd_ptr_reg        <= rd_ptr_next;
            rd_gray_reg       <= rd_ptr_next ^ (rd_ptr_next >> 1);
            wr_gray_sync1_reg <= wr_gray_reg;
            wr_gray_sync2_reg <= wr_gray_sync1_reg;
            rd_empty_reg      <= (rd_level_next == '0);
            almost_empty_reg  <= (rd_level_next <= AE_LEVEL);
            if (rd_accept) begin
                rd_data_reg <= rd_lanes[rd_ptr_reg[LANE_BITS-1:0]];
            end
        end
    end

    assign wr_full        = wr_full_reg;
    assign wr_water_level = wr_level_reg;
    assign almost_full    = almost_full_reg;
    assign rd_data        = rd_data_reg;
    assign rd_empty       = rd_empty_reg;
    assign almost_empty   = almost_empty_reg;

endmodule

// File: tb/tb_rd0_fifo_64to16.sv
// Scoreboard bench for rd0_fifo_64to16: both clock ports share one clock, both resets share tb_rst.
module tb_rd0_fifo_64to16;

    logic        clk = 1'b0;
    logic        tb_rst = 1'b0;
    logic [63:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_full, almost_full, rd_empty, almost_empty;
    logic [9:0]  wr_water_level;
    logic [15:0] rd_data;

    always #5 clk = ~clk;

    rd0_fifo_64to16 dut (
        .wr_clk         (clk),
        .rd_clk         (clk),
        .wr_rst         (tb_rst),
        .rd_rst         (tb_rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .almost_empty   (almost_empty)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] lane_q[$];
    logic        rd_pending = 1'b0;
    logic [15:0] rd_exp = '0;
    logic        underflow_seen = 1'b0;
    logic        overflow_seen = 1'b0;

    // One cycle starting at a negedge: drive, update the scoreboard from the sampled flags,
    // then return at the next negedge where the DUT result of this cycle is visible.
    task automatic step(input logic we, input logic [63:0] wd, input logic re);
        logic acc_w, acc_r;
        acc_w = we && !wr_full;
        acc_r = re && !rd_empty;
        wr_en = we;
        wr_data = wd;
        rd_en = re;
        rd_pending = 1'b0;
        underflow_seen = 1'b0;
        overflow_seen = 1'b0;
        if (acc_r) begin
            if (lane_q.size() == 0) underflow_seen = 1'b1;
            else begin
                rd_exp = lane_q.pop_front();
                rd_pending = 1'b1;
            end
        end
        if (acc_w) begin
            if ((lane_q.size() + 3) / 4 >= 512) overflow_seen = 1'b1;
            for (int k = 0; k < 4; k++) lane_q.push_back(wd[k*16 +: 16]);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic drain_all(input string tag);
        int guard;
        guard = 0;
        while (lane_q.size() > 0 && guard < 5000) begin
            step(1'b0, '0, 1'b1);
            guard++;
            if (rd_pending) begin
                n_checks++;
                if (rd_data !== rd_exp) $display("FAIL %s_data: got %h want %h", tag, rd_data, rd_exp);
                else n_pass++;
            end
        end
        n_checks++;
        if (lane_q.size() != 0) $display("FAIL %s_timeout: %0d lanes left want 0", tag, lane_q.size());
        else n_pass++;
        repeat (4) step(1'b0, '0, 1'b0);
        n_checks++;
        if (wr_water_level !== 10'd0 || rd_empty !== 1'b1)
            $display("FAIL %s_idle: level %0d empty %b want 0 1", tag, wr_water_level, rd_empty);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 tb_rst = 1'b1;
        #200;
        @(negedge clk);
        tb_rst = 1'b0;
        step(1'b0, '0, 1'b0);
        n_checks++; if (rd_empty !== 1'b1) $display("FAIL reset_rd_empty: got %b want 1", rd_empty); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty: got %b want 1", almost_empty); else n_pass++;
        n_checks++; if (wr_full !== 1'b0) $display("FAIL reset_wr_full: got %b want 0", wr_full); else n_pass++;
        n_checks++; if (wr_water_level !== 10'd0) $display("FAIL reset_level: got %0d want 0", wr_water_level); else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full: got %b want 0", almost_full); else n_pass++;
        n_checks++; if (rd_data !== 16'h0) $display("FAIL reset_rd_data: got %h want 0000", rd_data); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_fill();
        int exp_level;
        for (int i = 1; i <= 513; i++) begin
            step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF - 64'(i - 1), 1'b0);
            exp_level = (i > 512) ? 512 : i;
            n_checks++;
            if (wr_water_level !== 10'(exp_level)) $display("FAIL fill_level[%0d]: got %0d want %0d", i, wr_water_level, exp_level);
            else n_pass++;
            n_checks++;
            if (almost_full !== (exp_level >= 256)) $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, exp_level >= 256);
            else n_pass++;
            n_checks++;
            if (wr_full !== (exp_level == 512)) $display("FAIL fill_full[%0d]: got %b want %b", i, wr_full, exp_level == 512);
            else n_pass++;
        end
        $display("test_fill done: 513 writes issued");
    endtask

    task automatic test_drain();
        logic [15:0] first_lanes [8];
        logic [15:0] last_lane;
        first_lanes = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        last_lane = '0;
        repeat (4) step(1'b0, '0, 1'b0);
        n_checks++; if (almost_empty !== 1'b0) $display("FAIL drain_start_almost_empty: got %b want 0", almost_empty); else n_pass++;
        for (int i = 0; i <= 2048; i++) begin
            if (i < 2048) begin
                n_checks++;
                if (rd_empty !== 1'b0) $display("FAIL drain_not_empty[%0d]: got %b want 0", i, rd_empty);
                else n_pass++;
            end
            step(1'b0, '0, 1'b1);
            if (rd_pending) begin
                n_checks++;
                if (rd_data !== rd_exp) $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, rd_exp);
                else n_pass++;
            end
            if (i < 8) begin
                n_checks++;
                if (rd_data !== first_lanes[i]) $display("FAIL drain_lane_order[%0d]: got %h want %h", i, rd_data, first_lanes[i]);
                else n_pass++;
            end
            if (i == 2044) begin
                n_checks++;
                if (rd_data !== 16'hFE00) $display("FAIL drain_last_word_lane0: got %h want fe00", rd_data);
                else n_pass++;
            end
            if (i >= 2040 && i < 2048) begin
                n_checks++;
                if (almost_empty !== (2047 - i <= 4)) $display("FAIL drain_almost_empty[%0d]: got %b want %b", i, almost_empty, 2047 - i <= 4);
                else n_pass++;
            end
            if (i == 2047) begin
                last_lane = rd_exp;
                n_checks++;
                if (rd_empty !== 1'b1) $display("FAIL drain_empty_after_2048: got %b want 1", rd_empty);
                else n_pass++;
            end
            if (i == 2048) begin
                n_checks++;
                if (rd_data !== last_lane) $display("FAIL drain_hold_on_empty: got %h want %h", rd_data, last_lane);
                else n_pass++;
            end
        end
        repeat (4) step(1'b0, '0, 1'b0);
        n_checks++; if (wr_water_level !== 10'd0) $display("FAIL drain_level: got %0d want 0", wr_water_level); else n_pass++;
        n_checks++; if (wr_full !== 1'b0) $display("FAIL drain_full: got %b want 0", wr_full); else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL drain_almost_full: got %b want 0", almost_full); else n_pass++;
        $display("test_drain done: 2049 reads issued");
    endtask

    task automatic test_partial_word();
        step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        n_checks++; if (rd_empty !== 1'b0) $display("FAIL partial_not_empty: got %b want 0", rd_empty); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            n_checks++;
            if (!rd_pending || rd_data !== rd_exp) $display("FAIL partial_data[%0d]: got %h want %h", i, rd_data, rd_exp);
            else n_pass++;
        end
        repeat (5) step(1'b0, '0, 1'b0);
        n_checks++; if (wr_water_level !== 10'd1) $display("FAIL partial_level_3lanes: got %0d want 1", wr_water_level); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_checks++;
        if (!rd_pending || rd_data !== 16'h0123) $display("FAIL partial_lane3: got %h want 0123", rd_data);
        else n_pass++;
        repeat (3) step(1'b0, '0, 1'b0);
        n_checks++; if (wr_water_level !== 10'd0) $display("FAIL partial_level_freed: got %0d want 0", wr_water_level); else n_pass++;
        n_checks++; if (rd_empty !== 1'b1) $display("FAIL partial_empty: got %b want 1", rd_empty); else n_pass++;
        $display("test_partial_word done");
    endtask

    task automatic test_thresholds();
        step(1'b1, 64'hA000_0000_0000_0001, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        n_checks++; if (almost_empty !== 1'b1) $display("FAIL thr_ae_level4: got %b want 1", almost_empty); else n_pass++;
        n_checks++; if (rd_empty !== 1'b0) $display("FAIL thr_empty_level4: got %b want 0", rd_empty); else n_pass++;
        step(1'b1, 64'hA000_0000_0000_0002, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        n_checks++; if (almost_empty !== 1'b0) $display("FAIL thr_ae_level8: got %b want 0", almost_empty); else n_pass++;
        for (int i = 3; i <= 255; i++) step(1'b1, 64'hA000_0000_0000_0000 + 64'(i), 1'b0);
        n_checks++; if (wr_water_level !== 10'd255) $display("FAIL thr_level255: got %0d want 255", wr_water_level); else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL thr_af_level255: got %b want 0", almost_full); else n_pass++;
        step(1'b1, 64'hA000_0000_0000_0100, 1'b0);
        n_checks++; if (almost_full !== 1'b1) $display("FAIL thr_af_level256: got %b want 1", almost_full); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            n_checks++;
            if (rd_data !== rd_exp) $display("FAIL thr_data[%0d]: got %h want %h", i, rd_data, rd_exp);
            else n_pass++;
        end
        repeat (3) step(1'b0, '0, 1'b0);
        n_checks++; if (almost_full !== 1'b0) $display("FAIL thr_af_release: got %b want 0", almost_full); else n_pass++;
        drain_all("thr_drain");
        $display("test_thresholds done");
    endtask

    task automatic test_rd_empty_latency();
        logic exp_empty [4];
        exp_empty = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) step(1'b1, 64'h5555_6666_7777_8888, 1'b0);
            else step(1'b0, '0, 1'b0);
            n_checks++;
            if (rd_empty !== exp_empty[i]) $display("FAIL latency_empty[N+%0d]: got %b want %b", i, rd_empty, exp_empty[i]);
            else n_pass++;
        end
        drain_all("latency_drain");
        $display("test_rd_empty_latency done");
    endtask

    task automatic test_random();
        logic we, re;
        int   occ;
        for (int c = 0; c < 3000; c++) begin
            we = ($urandom_range(99, 0) < ((c < 1500) ? 45 : 15));
            re = ($urandom_range(99, 0) < ((c < 1500) ? 70 : 95));
            step(we, {$urandom, $urandom}, re);
            if (rd_pending) begin
                n_checks++;
                if (rd_data !== rd_exp) $display("FAIL random_data[%0d]: got %h want %h", c, rd_data, rd_exp);
                else n_pass++;
            end
            n_checks++;
            if (underflow_seen || overflow_seen) $display("FAIL random_flow[%0d]: underflow %b overflow %b want 0 0", c, underflow_seen, overflow_seen);
            else n_pass++;
            occ = (lane_q.size() + 3) / 4;
            n_checks++;
            if (int'(wr_water_level) < occ) $display("FAIL random_level[%0d]: got %0d want >= %0d", c, wr_water_level, occ);
            else n_pass++;
        end
        drain_all("random_drain");
        n_checks++; if (almost_empty !== 1'b1 || wr_full !== 1'b0) $display("FAIL random_final_flags: ae %b full %b want 1 0", almost_empty, wr_full); else n_pass++;
        $display("test_random done: 3000 cycles");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) step(1'b1, 64'hC0DE_0000_0000_1111 + 64'(i), 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        n_checks++; if (rd_data !== 16'h0000 + rd_exp) $display("FAIL midrst_pre_data: got %h want %h", rd_data, rd_exp); else n_pass++;
        #2 tb_rst = 1'b1;
        #1;
        n_checks++; if (wr_water_level !== 10'd0) $display("FAIL midrst_level: got %0d want 0", wr_water_level); else n_pass++;
        n_checks++; if (rd_empty !== 1'b1 || almost_empty !== 1'b1) $display("FAIL midrst_empty: got %b%b want 11", rd_empty, almost_empty); else n_pass++;
        n_checks++; if (rd_data !== 16'h0) $display("FAIL midrst_rd_data: got %h want 0000", rd_data); else n_pass++;
        lane_q.delete();
        @(negedge clk);
        tb_rst = 1'b0;
        repeat (2) step(1'b0, '0, 1'b0);
        step(1'b1, 64'hBEEF_CAFE_1234_9876, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        n_checks++; if (wr_water_level !== 10'd1) $display("FAIL midrst_post_level: got %0d want 1", wr_water_level); else n_pass++;
        drain_all("midrst_drain");
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_partial_word();
        test_thresholds();
        test_rd_empty_latency();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
